// File: rtl/div_pkg.sv
// Shared types and widths for the divider issue/capture slice.
// Used by div_issue_ctrl and the other divider variants.
package div_pkg;

    localparam int DIV_N_W = 16;
    localparam int DIV_D_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } div_state_e;

    typedef struct packed {
        logic [DIV_D_W-1:0] q;
        logic [DIV_D_W-1:0] r;
        logic               dz;
        logic               ovf;
    } div_res_t;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Operand and result valid/ready streams of div_issue_ctrl.
// Carries out_aerr only when DIV_RESIDUE_CHECK_EN is defined.
interface div_issue_ctrl_if
    import div_pkg::*;
#(
    parameter int N_W = DIV_N_W,
    parameter int D_W = DIV_D_W
);
    logic           in_valid;
    logic           in_ready;
    logic [N_W-1:0] in_n;
    logic [D_W-1:0] in_d;
    logic           out_valid;
    logic           out_ready;
    logic [D_W-1:0] out_q;
    logic [D_W-1:0] out_r;
    logic           out_dz;
    logic           out_ovf;
`ifdef DIV_RESIDUE_CHECK_EN
    logic           out_aerr;

    modport slave (
        input  in_valid, in_n, in_d, out_ready,
        output in_ready, out_valid, out_q, out_r,
        output out_dz, out_ovf, out_aerr
    );

    modport master (
        output in_valid, in_n, in_d, out_ready,
        input  in_ready, out_valid, out_q, out_r,
        input  out_dz, out_ovf, out_aerr
    );
`else
    modport slave (
        input  in_valid, in_n, in_d, out_ready,
        output in_ready, out_valid, out_q, out_r,
        output out_dz, out_ovf
    );

    modport master (
        output in_valid, in_n, in_d, out_ready,
        input  in_ready, out_valid, out_q, out_r,
        input  out_dz, out_ovf
    );
`endif
endinterface

// File: rtl/div_range_check.sv
// Combinational divide-by-zero / quotient-overflow screen.
// Only the dividend's upper half decides overflow.
module div_range_check #(
    parameter int D_W = 8
) (
    input  logic [D_W-1:0] n_hi,
    input  logic [D_W-1:0] d,
    output logic           dz,
    output logic           ovf
);

    assign dz  = (d == '0);
    assign ovf = !dz && (n_hi >= d);

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/capture controller around the combinational array divider.
// Optional residue check of the array result: DIV_RESIDUE_CHECK_EN.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int N_W           = DIV_N_W,
    parameter int D_W           = DIV_D_W,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    div_issue_ctrl_if.slave bus,
    output logic [N_W-1:0] div_n,
    output logic [D_W-1:0] div_d,
    input  logic [D_W-1:0] div_q,
    input  logic [D_W-1:0] div_r
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    div_state_e state;
    div_state_e state_nxt;
    logic [3:0] cnt;
    div_res_t   res;
    logic       dz;
    logic       ovf;
    logic       accept;
    logic       cap;
    logic       aerr;
    logic       aerr_nxt;

    div_range_check #(
        .D_W (D_W)
    ) u_range (
        .n_hi (bus.in_n[N_W-1:D_W]),
        .d    (bus.in_d),
        .dz   (dz),
        .ovf  (ovf)
    );

`ifdef DIV_RESIDUE_CHECK_EN
    logic [N_W-1:0] prod;
    logic [N_W-1:0] resid;

    // q*d + r must rebuild the dividend and r must stay below d
    assign prod     = {{(N_W-D_W){1'b0}}, div_q}
                    * {{(N_W-D_W){1'b0}}, div_d};
    assign resid    = prod + {{(N_W-D_W){1'b0}}, div_r};
    assign aerr_nxt = (resid != div_n) | (div_r >= div_d);
    assign bus.out_aerr = aerr;
`else
    assign aerr_nxt = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        cap           = 1'b0;
        unique case (1'b1)
            (state == IDLE): begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = (dz | ovf) ? DONE : SETTLE;
                end
            end
            (state == SETTLE): begin
                if (cnt == '0) begin
                    cap       = 1'b1;
                    state_nxt = DONE;
                end
            end
            (state == DONE): begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_n <= '0;
            div_d <= '0;
            cnt   <= '0;
            res   <= '0;
            aerr  <= 1'b0;
        end else if (accept) begin
            div_n <= bus.in_n;
            div_d <= bus.in_d;
            cnt   <= CNT_INIT;
            if (dz | ovf) begin
                res.q   <= '1;
                res.r   <= dz ? bus.in_n[D_W-1:0] : '0;
                res.dz  <= dz;
                res.ovf <= ovf;
                aerr    <= 1'b0;
            end
        end else if (cap) begin
            res.q   <= div_q;
            res.r   <= div_r;
            res.dz  <= 1'b0;
            res.ovf <= 1'b0;
            aerr    <= aerr_nxt;
        end else if (state == SETTLE) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign bus.out_q   = res.q;
    assign bus.out_r   = res.r;
    assign bus.out_dz  = res.dz;
    assign bus.out_ovf = res.ovf;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl (SETTLE_CYCLES = 1).
// Vector table plus reset-abort sequence, scoreboard on results.
module tb_div_issue_ctrl;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] div_n;
    logic [7:0]  div_d;
    logic [7:0]  div_q;
    logic [7:0]  div_r;
    logic        force_bad = 1'b0;
    int          n_vec = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    div_issue_ctrl_if bus ();

    div_issue_ctrl #(
        .SETTLE_CYCLES (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .div_n (div_n),
        .div_d (div_d),
        .div_q (div_q),
        .div_r (div_r)
    );

    // Array stand-in: exact divider, or a deliberately wrong result
    always_comb begin
        div_q = '1;
        div_r = '0;
        if (force_bad) begin
            div_q = 8'd14;
            div_r = 8'd3;
        end else if (div_d != 0) begin
            div_q = 8'(div_n / {8'd0, div_d});
            div_r = 8'(div_n % {8'd0, div_d});
        end
    end

    typedef struct {
        logic [15:0] n;
        logic [7:0]  d;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dz;
        logic        ovf;
        logic        aerr;
        int          lat;
        int          hold;
        logic        bad;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ovf;
        logic       aerr;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        int   cyc;
        exp_t e;
        exp_t g;
        force_bad = v.bad;
        cyc = 0;
        while (!bus.in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("in_ready_wait", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_n = v.n;
        bus.in_d = v.d;
        e = '{v.q, v.r, v.dz, v.ovf, v.aerr};
        sb.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("div_n_reg", 32'(div_n), 32'(v.n));
        chk("div_d_reg", 32'(div_d), 32'(v.d));
        cyc = 1;
        while (!bus.out_valid && cyc < 40) begin
            chk("in_ready_settle", 32'(bus.in_ready), 0);
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(v.lat));
        if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard_empty: got 0 want 1");
        end else begin
            g = sb.pop_front();
            chk("out_q", 32'(bus.out_q), 32'(g.q));
            chk("out_r", 32'(bus.out_r), 32'(g.r));
            chk("out_dz", 32'(bus.out_dz), 32'(g.dz));
            chk("out_ovf", 32'(bus.out_ovf), 32'(g.ovf));
`ifdef DIV_RESIDUE_CHECK_EN
            chk("out_aerr", 32'(bus.out_aerr), 32'(g.aerr));
`endif
            // a pending operand in DONE must not be consumed
            bus.in_valid = 1'b1;
            bus.in_n = 16'h0055;
            bus.in_d = 8'h00;
            for (int i = 0; i < v.hold; i++) begin
                @(posedge clk); #1;
                chk("hold_valid", 32'(bus.out_valid), 1);
                chk("hold_q", 32'(bus.out_q), 32'(g.q));
                chk("hold_r", 32'(bus.out_r), 32'(g.r));
                chk("hold_dz", 32'(bus.out_dz), 32'(g.dz));
                chk("hold_in_ready", 32'(bus.in_ready), 0);
            end
            bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        force_bad = 1'b0;
        chk("valid_drop", 32'(bus.out_valid), 0);
        chk("ready_back", 32'(bus.in_ready), 1);
        chk("div_n_kept", 32'(div_n), 32'(v.n));
        chk("div_d_kept", 32'(div_d), 32'(v.d));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_n = '0;
        bus.in_d = '0;

        tbl.push_back('{16'd100, 8'd7, 8'd14, 8'd2,
                        1'b0, 1'b0, 1'b0, 2, 0, 1'b0});
        tbl.push_back('{16'h1234, 8'd0, 8'hFF, 8'h34,
                        1'b1, 1'b0, 1'b0, 1, 0, 1'b0});
        tbl.push_back('{16'h0800, 8'd8, 8'hFF, 8'h00,
                        1'b0, 1'b1, 1'b0, 1, 2, 1'b0});
        tbl.push_back('{16'd255, 8'd16, 8'd15, 8'd15,
                        1'b0, 1'b0, 1'b0, 2, 5, 1'b0});
        tbl.push_back('{16'hFEFF, 8'hFF, 8'hFF, 8'hFE,
                        1'b0, 1'b0, 1'b0, 2, 0, 1'b0});
        tbl.push_back('{16'hFFFF, 8'hFF, 8'hFF, 8'h00,
                        1'b0, 1'b1, 1'b0, 1, 0, 1'b0});
        tbl.push_back('{16'h07FF, 8'd8, 8'hFF, 8'd7,
                        1'b0, 1'b0, 1'b0, 2, 1, 1'b0});
        tbl.push_back('{16'd0, 8'd1, 8'd0, 8'd0,
                        1'b0, 1'b0, 1'b0, 2, 0, 1'b0});
`ifdef DIV_RESIDUE_CHECK_EN
        tbl.push_back('{16'd100, 8'd7, 8'd14, 8'd3,
                        1'b0, 1'b0, 1'b1, 2, 1, 1'b1});
        tbl.push_back('{16'd100, 8'd7, 8'd14, 8'd2,
                        1'b0, 1'b0, 1'b0, 2, 0, 1'b0});
`endif

        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_q", 32'(bus.out_q), 0);
        chk("rst_out_r", 32'(bus.out_r), 0);
        chk("rst_flags", 32'({bus.out_dz, bus.out_ovf}), 0);
        chk("rst_div_n", 32'(div_n), 0);
        chk("rst_div_d", 32'(div_d), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) run_op(tbl[i]);

        // reset while the 50/5 operation sits in SETTLE
        bus.in_valid = 1'b1;
        bus.in_n = 16'd50;
        bus.in_d = 8'd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("abort_in_settle", 32'(bus.in_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(bus.out_valid), 0);
        chk("abort_ready", 32'(bus.in_ready), 1);
        chk("abort_div_n", 32'(div_n), 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort_no_out", 32'(bus.out_valid), 0);
            chk("abort_idle", 32'(bus.in_ready), 1);
        end

        run_op(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Sequential issue/capture controller that sits in front of, and behind, the 16/8 combinational array divider.
- Accepts dividend/divisor pairs over a valid/ready stream and registers the operands that drive the divider array.
- Waits a programmable number of settle cycles for the array's multicycle path, then captures quotient/remainder into an output valid/ready stream.
- Screens divide-by-zero and quotient overflow before issue, so the array is never trusted on out-of-range operands.

Parameters:
- N_W, 16, dividend width; must equal 2*D_W.
- D_W, 8, divisor/quotient/remainder width.
- SETTLE_CYCLES, 1, cycles the registered operands are held before the array outputs are captured; legal range 1..15.

Ports:
- clk  in  1  single clock; all flops rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept an operand pair.
- in_n  in  N_W  dividend.
- in_d  in  D_W  divisor.
- div_n  out  N_W  registered dividend to the divider array.
- div_d  out  D_W  registered divisor to the divider array.
- div_q  in  D_W  quotient from the divider array.
- div_r  in  D_W  remainder from the divider array.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_q  out  D_W  captured quotient.
- out_r  out  D_W  captured remainder.
- out_dz  out  1  divide-by-zero flag.
- out_ovf  out  1  overflow flag, set when in_n[N_W-1:D_W] >= in_d and in_d != 0.

Behaviour:
- Reset values (rst_n=0, immediate, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0.
  - div_n, div_d, out_q, out_r, out_dz, out_ovf all 0.
  - Settle counter 0.
- FSM states: IDLE, SETTLE, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: register in_n→div_n and in_d→div_d.
  - Compute dz=(in_d==0) and ovf=(!dz & in_n[N_W-1:D_W] >= in_d).
  - If dz|ovf: go to DONE. out_q=all ones; out_r=in_n[D_W-1:0] for dz, 0 for ovf; flags set as computed. Latency is 1 cycle.
  - Otherwise: load counter=SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE:
  - in_ready=0.
  - div_n/div_d held constant.
  - Counter decrements each cycle.
  - When the counter is 0: capture div_q→out_q and div_r→out_r, clear both flags, go to DONE.
  - Accept-to-out_valid latency is SETTLE_CYCLES+1 cycles (2 at default).
- DONE:
  - out_valid=1; out_* held stable while out_ready=0 (no change until the handshake).
  - On out_ready: go to IDLE; out_valid drops the next cycle.
  - in_ready stays 0 in DONE; there is no overlap.
- Throughput: one operation per SETTLE_CYCLES+2 cycles at minimum (the IDLE accept cycle, SETTLE_CYCLES cycles, one DONE cycle).
- Boundary conditions:
  - in_valid is ignored outside IDLE.
  - in_valid held high while in DONE is not consumed until the controller returns to IDLE.
  - div_n/div_d keep their last values when IDLE; they are not cleared.
  - Reset mid-SETTLE or mid-DONE aborts the operation and drops out_valid immediately; no result is emitted.
- Width rules: comparisons are unsigned, using D_W-bit compares only; no arithmetic on the quotient path.

Optional Feature:
- Macro: DIV_RESIDUE_CHECK_EN.
- When defined:
  - Add output port out_aerr (1 bit).
  - In the SETTLE capture cycle, compute div_q*div_d + div_r (N_W bits, unsigned, carry discarded) and compare it against div_n.
  - Also flag div_r >= div_d.
  - out_aerr=1 if either check fails; this detects approximate-cell error.
  - out_aerr=0 for dz/ovf results; it resets to 0 and is held with the other out_* in DONE.
- When undefined: the port, multiplier and comparator are absent; behaviour is otherwise identical.

Decomposition:
- Shared package div_pkg holds:
  - Constants DIV_N_W=16 and DIV_D_W=8.
  - FSM state typedef div_state_e (IDLE, SETTLE, DONE).
  - Result struct div_res_t (q, r, dz, ovf).
- One natural sub-module: div_range_check (combinational dz/ovf screen), reused by other divider variants.
- The residue checker stays inline under the macro.

Test Plan:
- Bench drives div_q/div_r from an exact behavioural divider model unless stated otherwise.
- in_n=100, in_d=7, SETTLE_CYCLES=1 → out_valid exactly 2 cycles after accept; out_q=14, out_r=2, out_dz=0, out_ovf=0.
- in_n=0x1234, in_d=0 → out_valid 1 cycle after accept; out_q=0xFF, out_r=0x34, out_dz=1.
- in_n=0x0800, in_d=8 (upper byte 8 >= 8) → out_ovf=1, out_q=0xFF, out_r=0, array result not captured.
- in_n=255, in_d=16 with out_ready held 0 for 5 cycles → out_q=15, out_r=15 stable for all 5 cycles, in_ready=0 throughout; both handshakes complete back-to-back at the first legal cycles.
- rst_n pulsed low in the SETTLE cycle of in_n=50, in_d=5 → out_valid never asserts; in_ready=1 the cycle after release.
- With DIV_RESIDUE_CHECK_EN, model forces div_q=14, div_r=3 for in_n=100, in_d=7 → out_aerr=1; with the exact model driving div_q/div_r, out_aerr=0.
